// File: rtl/inv_shift_rows_stage.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stage
//
// Registered AES InvShiftRows stage for the decryption datapath. Each accepted
// 128-bit state is permuted on the way in and parked in a 2-entry elastic
// buffer, so stalls on either side never drop or reorder blocks.
//
// Byte layout: byte k = bits [8k:8k+7], row k%4, column k/4.
// Permutation: out[row r, col c] = in[row r, col (c-r) mod 4].
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of all buffered blocks (beats push and pop)
//   in_valid   upstream block valid
//   in_ready   stage can accept a block this cycle
//   in_state   input state [0:127]
//   out_valid  out_state holds a valid block
//   out_ready  downstream accepts
//   out_state  InvShiftRows result (oldest buffered block)
//   blk_count  number of output handshakes since reset, wraps at 2^COUNT_W
//
// Optional feature, macro ISR_PARITY_EN:
//   in_parity  [0:15] even parity per input byte
//   out_parity [0:15] parity permuted and buffered alongside the data
//   parity_err sticky flag, set when a pushed byte disagrees with its parity;
//              cleared only by rst. The block itself is passed through.
// -----------------------------------------------------------------------------
module inv_shift_rows_stage #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       out_state,
    output logic [COUNT_W-1:0] blk_count
`ifdef ISR_PARITY_EN
    ,
    input  logic [0:15]        in_parity,
    output logic [0:15]        out_parity,
    output logic               parity_err
`endif
);

    // Source byte index for output byte j: same row, column shifted back by row.
    function automatic int src_byte(input int j);
        return 4 * (((j / 4) - (j % 4)) & 3) + (j % 4);
    endfunction

    function automatic logic [0:127] inv_shift(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[8*j +: 8] = s[8*src_byte(j) +: 8];
        end
        return r;
    endfunction

    logic [0:127] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    // in_ready depends only on registered occupancy and flush, never on
    // out_ready, so a full buffer cannot accept even when a pop is coming.
    assign in_ready  = (cnt != 2'd2) && !flush;
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign out_state = mem[rd_ptr];

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            blk_count <= '0;
        end else if (flush) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                blk_count <= blk_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the two entries are reset explicitly so out_state reads zero after
    // reset; it is a flop pair, not a RAM, so the reset costs nothing special.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= inv_shift(in_state);
        end
    end

`ifdef ISR_PARITY_EN
    logic [0:15] par_mem [2];
    logic [0:15] par_perm;
    logic        par_bad;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        par_perm = '0;
        par_bad  = 1'b0;
        for (int j = 0; j < 16; j++) begin
            par_perm[j] = in_parity[src_byte(j)];
            if ((^in_state[8*j +: 8]) != in_parity[j]) par_bad = 1'b1;
        end
    end

    assign out_parity = par_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_mem[0] <= '0;
            par_mem[1] <= '0;
            parity_err <= 1'b0;
        end else if (push) begin
            par_mem[wr_ptr] <= par_perm;
            if (par_bad) parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
module tb_inv_shift_rows_stage;

    localparam int CW = 4;  // small counter so the wrap is exercised

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [0:127]  in_state;
    logic          out_valid;
    logic          out_ready;
    logic [0:127]  out_state;
    logic [CW-1:0] blk_count;
`ifdef ISR_PARITY_EN
    logic [0:15]   in_parity;
    logic [0:15]   out_parity;
    logic          parity_err;
    logic [0:15]   par_flip = '0;
`endif

    inv_shift_rows_stage #(.COUNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .blk_count (blk_count)
`ifdef ISR_PARITY_EN
        ,
        .in_parity (in_parity),
        .out_parity(out_parity),
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [0:127]  exp_q[$];
    logic [CW-1:0] model_cnt = '0;
    logic          stall_prev = 1'b0;
    logic [0:127]  prev_state;
    int            last_wait;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model on a 4x4 byte matrix: state[r][c] is byte 4c+r.
    function automatic logic [0:127] rotate_rows(input logic [0:127] s, input bit inverse);
        logic [7:0]   m [4][4];
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[32*c + 8*r +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = inverse ? m[r][(c - r + 4) % 4] : m[r][(c + r) % 4];
        return o;
    endfunction

    function automatic logic [0:127] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: checks handshake flags, counter and data every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 128'(in_ready), 128'(exp_q.size() != 2 && !flush));
            check("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
            check("blk_count", 128'(blk_count), 128'(model_cnt));
            if (stall_prev) check("stall_hold", out_state, prev_state);
            if (out_valid && out_ready && !flush && exp_q.size() != 0) begin
                check("out_state", out_state, exp_q.pop_front());
                model_cnt = model_cnt + 1'b1;
            end
            stall_prev = out_valid && !out_ready && !flush;
            prev_state = out_state;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Present a block until accepted (bounded); record its expected output.
    task automatic send(input logic [0:127] d, input logic [0:127] e);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_state = d;
`ifdef ISR_PARITY_EN
        for (int k = 0; k < 16; k++) in_parity[k] = ^d[8*k +: 8];
        in_parity = in_parity ^ par_flip;
`endif
        last_wait = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            last_wait++;
            @(posedge clk);
            #1;
        end
        if (ok) exp_q.push_back(e);
        else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [0:127]  a, b, c, d;
        logic [CW-1:0] b0;
        int            cyc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
`ifdef ISR_PARITY_EN
        in_parity = '0;
`endif
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_blk_count", 128'(blk_count), 128'(0));
        check("rst_out_state", out_state, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'(1));
`ifdef ISR_PARITY_EN
        check("rst_parity_err", 128'(parity_err), 128'(0));
`endif

        // Directed vector with a hand-derived expectation.
        out_ready = 1'b1;
        send(128'h000102030405060708090A0B0C0D0E0F, 128'h000D0A07_04010E0B_0805020F_0C090603);
        in_valid = 1'b0;
        drain();
        check("first_blk_count", 128'(blk_count), 128'(1));

        // Round trip through the encryption-side ShiftRows.
        a = 128'h00112233445566778899AABBCCDDEEFF;
        send(rotate_rows(a, 1'b0), a);
        in_valid = 1'b0;
        drain();

        // Backpressure: fill both entries, hold a third, then release.
        out_ready = 1'b0;
        a = rand_block(); b = rand_block(); c = rand_block();
        send(a, rotate_rows(a, 1'b1));
        send(b, rotate_rows(b, 1'b1));
        in_valid = 1'b1; in_state = c;
`ifdef ISR_PARITY_EN
        for (int k = 0; k < 16; k++) in_parity[k] = ^c[8*k +: 8];
`endif
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(c, rotate_rows(c, 1'b1));
        in_valid = 1'b0;
        drain();

        // Streaming: 100 back-to-back blocks, no bubbles, counter wraps.
        b0 = model_cnt;
        cyc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = rand_block();
            send(d, rotate_rows(d, 1'b1));
            cyc += last_wait;
        end
        in_valid = 1'b0;
        drain();
        check("stream_cycles", 128'(cyc), 128'(100));
        check("stream_blk_count", 128'(blk_count), 128'(CW'(b0 + CW'(100))));

        // Flush with a full buffer, a pending input and a would-be pop.
        out_ready = 1'b0;
        a = rand_block(); b = rand_block();
        send(a, rotate_rows(a, 1'b1));
        send(b, rotate_rows(b, 1'b1));
        b0 = model_cnt;
        in_valid = 1'b1; in_state = rand_block();
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_blk_count", 128'(blk_count), 128'(b0));
        repeat (2) @(posedge clk);
        #1;

`ifdef ISR_PARITY_EN
        // Corrupted parity on input byte 5: data still passes, flag sticks.
        out_ready = 1'b1;
        par_flip = 16'h0400;
        a = rand_block();
        send(a, rotate_rows(a, 1'b1));
        par_flip = '0;
        b = rand_block();
        send(b, rotate_rows(b, 1'b1));
        in_valid = 1'b0;
        drain();
        check("parity_err_set", 128'(parity_err), 128'(1));
`endif

        // Asynchronous reset between edges with blocks buffered.
        out_ready = 1'b0;
        a = rand_block(); b = rand_block();
        send(a, rotate_rows(a, 1'b1));
        send(b, rotate_rows(b, 1'b1));
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 128'(out_valid), 128'(0));
        check("async_rst_blk_count", 128'(blk_count), 128'(0));
        check("async_rst_out_state", out_state, 128'(0));
`ifdef ISR_PARITY_EN
        check("async_rst_parity_err", 128'(parity_err), 128'(0));
`endif
        exp_q.delete();
        model_cnt = '0;
        stall_prev = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        a = rand_block();
        send(a, rotate_rows(a, 1'b1));
        in_valid = 1'b0;
        drain();
        check("post_rst_blk_count", 128'(blk_count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_shift_rows_stage.md
Name: inv_shift_rows_stage

Overview:
Registered AES InvShiftRows stage for the decryption datapath; the inverse of the encryption-side ShiftRows permutation.
- Accepts a 128-bit state over a valid/ready handshake and applies the inverse row rotation.
- Holds results in a 2-entry elastic buffer so upstream/downstream stalls do not drop blocks.
- Sits between the decryption round's InvSubBytes output and AddRoundKey input.

Parameters:
COUNT_W, 16, width of the delivered-block counter blk_count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of buffered blocks
in_valid  input  1  upstream block valid
in_ready  output  1  stage can accept a block this cycle
in_state  input  [0:127]  input state; byte k = bits [8k:8k+7]; byte k is row k%4, column k/4
out_valid  output  1  out_state holds a valid block
out_ready  input  1  downstream accepts
out_state  output  [0:127]  InvShiftRows result, same byte layout
blk_count  output  COUNT_W  number of output handshakes since reset

Behaviour:
- One clock, clk; reset rst is asynchronous, active-high. The polarity and synchronicity are fixed.
- Permutation: out[row r, col c] = in[row r, col (c-r) mod 4].
- As an output-byte list of input byte indices: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- Row 0 is unrotated. Row 1 rotates right by 1, row 2 by 2, row 3 by 3.
- The permutation is applied on the input side. Buffer entries store permuted data.
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Buffer: 2 entries, occupancy cnt in 0..2.
- in_ready = (cnt != 2) && !flush. It comes from registered occupancy only, with no combinational path from out_ready.
- out_valid = (cnt != 0).
- out_state always shows the oldest entry. It is stable while out_valid && !out_ready.
- Latency: a block pushed at edge N has out_valid=1 and the correct out_state after edge N (1 cycle).
- Throughput: 1 block/cycle when out_ready is held high.
- Simultaneous push and pop:
  - cnt=1: cnt stays 1; the new block becomes head on the following edge.
  - cnt=2: no push is possible (in_ready=0); pop alone leaves cnt=1.
- Ordering: strict FIFO, no reordering, no drops.
- blk_count increments by 1 on each pop, modulo 2^COUNT_W (wraps from all-ones to 0). It does not change on flush.
- flush=1 at an edge:
  - cnt->0 and any in-flight push is ignored; in_ready is low in that cycle.
  - A pop in the same cycle is not counted.
  - flush has priority over push and pop.
- Reset values: cnt=0, out_valid=0, in_ready=1 (once rst is low), out_state=0, blk_count=0, entry registers=0.
- Reset asserted mid-transfer discards all buffered blocks immediately (asynchronous). No handshake completes in that cycle.
- Behaviour is undefined while in_state changes with in_valid=1 and in_ready=0. Upstream must hold in_state until accepted.

Optional Feature:
Macro ISR_PARITY_EN.

When defined:
- Adds in_parity input [0:15]: even parity per input byte, indexed by input byte number.
- Adds out_parity output [0:15]: parity bits permuted with the same byte map and buffered alongside the data.
- Adds parity_err output 1 (sticky, reset 0), set when any pushed byte's parity mismatches in_parity. It is cleared only by rst.
- A mismatched block is still passed through unchanged.

When undefined:
- These ports and their logic do not exist.
- Data behaviour is identical.

Test Plan:
- Reset, then push in_state=000102030405060708090A0B0C0D0E0F with out_ready=1 -> one cycle later out_valid=1, out_state=000D0A07_04010E0B_0805020F_0C090603, blk_count becomes 1 after the pop.
- Round trip: apply the encryption ShiftRows to 00112233445566778899AABBCCDDEEFF, then feed the result through this stage -> out_state=00112233445566778899AABBCCDDEEFF.
- Backpressure: out_ready=0, push blocks A and B -> in_ready=0 with cnt=2, block C is held. Raise out_ready -> A, B, C are delivered in order, and out_state is stable during the stall.
- Streaming: 100 back-to-back random blocks with out_ready=1 -> 100 outputs, each matching the reference permutation, no bubbles after the first, blk_count=100.
- Flush with cnt=2 and an in_valid present -> next cycle out_valid=0, the pending input is not accepted, blk_count unchanged.
- Asynchronous rst pulsed mid-stream between clock edges -> out_valid=0 and blk_count=0 immediately. Under ISR_PARITY_EN, a corrupted in_parity bit 5 sets parity_err=1 and it stays set until rst.
